// File: rtl/pipelined_cla_adder_if.sv
// pipelined_cla_adder_if
//   Operand/result bundle for pipelined_cla_adder.
//   Parameter WIDTH must match the adder it connects to.
//
//   Producer side : in_valid, in_ready, a, b, cin, sub
//   Consumer side : out_valid, out_ready, sum, cout, overflow, zero
//
//   Modports:
//     slave  - the adder (takes operands, returns results)
//     master - whoever feeds operands and consumes results
interface pipelined_cla_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow, zero
  );

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow, zero
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
//   Two-stage pipelined carry-lookahead adder/subtractor, the ALU add/sub
//   datapath.  Computes sum = a + b' + c0 with b' = sub ? ~b : b and
//   c0 = sub ? 1 : cin.
//
//   Stage 1 registers bit propagate/generate, group propagate/generate
//   (WIDTH/GROUP groups of GROUP bits) and c0.  Stage 2 resolves group
//   carries, then in-group bit carries, and registers sum and flags.
//
//   Parameters:
//     WIDTH - operand/result width, multiple of GROUP, >= GROUP
//     GROUP - bits per lookahead group: 2, 4 or 8
//
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous active-high reset
//     bus  - pipelined_cla_adder_if.slave
//            in_valid/in_ready/a/b/cin/sub   operand channel
//            out_valid/out_ready/sum/cout/overflow/zero result channel
//
//   Build option:
//     CLA_FLAGS_EN - when defined, overflow and zero are computed and
//                    registered in stage 2; otherwise both read 0.
//
//   Handshake (both channels): a transfer happens on a rising edge where
//   valid & ready are both 1.  The sender holds valid and payload until
//   the transfer; ready may depend combinationally on the downstream ready
//   (in_ready follows out_ready through s2_adv).  While out_valid=1 and
//   out_ready=0 the result outputs hold stable.
module pipelined_cla_adder #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  pipelined_cla_adder_if.slave bus
);

  localparam int NG = WIDTH / GROUP;

  // Handshake / pipeline control
  logic s1_valid_d, s1_valid_q;
  logic s2_valid_d, s2_valid_q;
  logic s2_adv;
  logic s1_load;
  logic s2_load;

  // Stage 1 state
  logic [WIDTH-1:0] p_d, p_q;
  logic [WIDTH-1:0] g_d, g_q;
  logic [NG-1:0]    gp_d, gp_q;
  logic [NG-1:0]    gg_d, gg_q;
  logic             c0_d, c0_q;

  // Stage 2 state
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
`ifdef CLA_FLAGS_EN
  logic             overflow_d, overflow_q;
  logic             zero_d, zero_q;
`endif

  // S2 can take new data when empty or when its result leaves this cycle.
  // S1 can take new data when empty or when it can move into S2.
  always_comb begin
    s2_adv     = !s2_valid_q || bus.out_ready;
    s1_load    = bus.in_valid && (!s1_valid_q || s2_adv);
    s2_load    = s1_valid_q && s2_adv;
    s1_valid_d = s1_load || (s1_valid_q && !s2_adv);
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
  end

  // Stage 1: effective operand, bit and group propagate/generate.
  always_comb begin : s1_comb
    logic [WIDTH-1:0] b_eff;
    logic             pk;
    logic             gk;
    b_eff = bus.sub ? ~bus.b : bus.b;
    c0_d  = bus.sub | bus.cin;
    p_d   = bus.a ^ b_eff;
    g_d   = bus.a & b_eff;
    gp_d  = '0;
    gg_d  = '0;
    for (int k = 0; k < NG; k++) begin
      pk = 1'b1;
      gk = 1'b0;
      // Walking LSB->MSB builds g[msb] | p[msb]&g[msb-1] | ... incrementally.
      for (int i = 0; i < GROUP; i++) begin
        pk = pk & p_d[k*GROUP + i];
        gk = g_d[k*GROUP + i] | (p_d[k*GROUP + i] & gk);
      end
      gp_d[k] = pk;
      gg_d[k] = gk;
    end
  end

  // Stage 2: group carries from registered P/G, then bit carries within each
  // group seeded by that group's carry-in.
  always_comb begin : s2_comb
    logic [NG:0]    gc;
    logic [WIDTH:0] c;
    gc    = '0;
    c     = '0;
    gc[0] = c0_q;
    for (int k = 0; k < NG; k++) begin
      gc[k+1] = gg_q[k] | (gp_q[k] & gc[k]);
    end
    for (int k = 0; k < NG; k++) begin
      c[k*GROUP] = gc[k];
      for (int i = 0; i < GROUP; i++) begin
        c[k*GROUP + i + 1] = g_q[k*GROUP + i] | (p_q[k*GROUP + i] & c[k*GROUP + i]);
      end
    end
    // The top group's carry-out equals gc[NG]; take it from the lookahead path.
    c[WIDTH] = gc[NG];
    sum_d    = p_q ^ c[WIDTH-1:0];
    cout_d   = c[WIDTH];
`ifdef CLA_FLAGS_EN
    overflow_d = c[WIDTH] ^ c[WIDTH-1];
    zero_d     = (sum_d == '0);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      p_q        <= '0;
      g_q        <= '0;
      gp_q       <= '0;
      gg_q       <= '0;
      c0_q       <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
`ifdef CLA_FLAGS_EN
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (s1_load) begin
        p_q  <= p_d;
        g_q  <= g_d;
        gp_q <= gp_d;
        gg_q <= gg_d;
        c0_q <= c0_d;
      end
      if (s2_load) begin
        sum_q      <= sum_d;
        cout_q     <= cout_d;
`ifdef CLA_FLAGS_EN
        overflow_q <= overflow_d;
        zero_q     <= zero_d;
`endif
      end
    end
  end

  assign bus.in_ready  = !s1_valid_q || s2_adv;
  assign bus.out_valid = s2_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
`ifdef CLA_FLAGS_EN
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.zero      = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder
//   Self-checking bench for pipelined_cla_adder at WIDTH=32, GROUP=4.
//   Expected results come from plain arithmetic on a + b' + c0; signed
//   overflow from operand/result sign bits.  Flag expectations follow
//   CLA_FLAGS_EN the same way the design build does.
module tb_pipelined_cla_adder;

  localparam int W = 32;
  localparam int G = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [W+2:0] exp_q[$];

  pipelined_cla_adder_if #(.WIDTH(W)) bus();

  pipelined_cla_adder #(.WIDTH(W), .GROUP(G)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  // Returns {zero, overflow, cout, sum}.
  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         ovf;
    logic         z;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    z    = (full[W-1:0] == '0);
`ifndef CLA_FLAGS_EN
    ovf = 1'b0;
    z   = 1'b0;
`endif
    return {z, ovf, full[W], full[W-1:0]};
  endfunction

  function automatic logic [W+2:0] observed();
    return {bus.zero, bus.overflow, bus.cout, bus.sum};
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic drive_idle();
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
  endtask

  task automatic drive_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic sub);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.sub      = sub;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    bus.out_ready = 1'b1;
    #2;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    checks++;
    if (observed() !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", observed());
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] va[5];
    logic [W-1:0] vb[5];
    logic         vc[5];
    logic         vs[5];
    logic [W+2:0] exp;
    va = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5, 32'd7, 32'd3};
    vb = '{32'h0000_0001, 32'h0000_0001, 32'd7, 32'd5, 32'd4};
    vc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vs = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int t = 0; t < 5; t++) begin
      exp = model(va[t], vb[t], vc[t], vs[t]);
      @(negedge clk);
      bus.out_ready = 1'b1;
      drive_txn(va[t], vb[t], vc[t], vs[t]);
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL dir%0d_in_ready: got %b expected 1", t, bus.in_ready);
      end
      @(negedge clk);
      drive_idle();
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL dir%0d_early_valid: got %b expected 0", t, bus.out_valid);
      end
      @(negedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1) begin
        errors++; $display("FAIL dir%0d_latency: out_valid %b expected 1", t, bus.out_valid);
      end
      checks++;
      if (bus.sum !== exp[W-1:0]) begin
        errors++; $display("FAIL dir%0d_sum: got %h expected %h", t, bus.sum, exp[W-1:0]);
      end
      checks++;
      if (bus.cout !== exp[W]) begin
        errors++; $display("FAIL dir%0d_cout: got %b expected %b", t, bus.cout, exp[W]);
      end
      checks++;
      if ({bus.zero, bus.overflow} !== exp[W+2:W+1]) begin
        errors++; $display("FAIL dir%0d_flags: zero/ovf got %b%b expected %b",
                           t, bus.zero, bus.overflow, exp[W+2:W+1]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int idx;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b0;
      if (idx < 4) drive_txn(W'(idx + 1), W'(idx + 1), 1'b0, 1'b0);
      else drive_idle();
      #1;
      if (c >= 2) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin
          errors++; $display("FAIL bp_in_ready_c%0d: got %b expected 0", c, bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.sum !== W'(2)) begin
          errors++; $display("FAIL bp_hold_c%0d: valid %b sum %h expected valid 1 sum 2",
                             c, bus.out_valid, bus.sum);
        end
      end
      if (bus.in_valid && bus.in_ready) idx++;
    end
    checks++;
    if (idx != 2) begin
      errors++; $display("FAIL bp_accepts: got %0d expected 2", idx);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      if (idx < 4) drive_txn(W'(idx + 1), W'(idx + 1), 1'b0, 1'b0);
      else drive_idle();
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.sum !== W'(2 * (c + 1))) begin
        errors++; $display("FAIL bp_drain_%0d: valid %b sum %h expected valid 1 sum %h",
                           c, bus.out_valid, bus.sum, W'(2 * (c + 1)));
      end
      if (bus.in_valid && bus.in_ready) idx++;
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || idx != 4) begin
      errors++; $display("FAIL bp_end: valid %b accepts %0d expected valid 0 accepts 4",
                         bus.out_valid, idx);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive_txn(W'(10), W'(10), 1'b0, 1'b0);
    @(negedge clk);
    drive_txn(W'(11), W'(11), 1'b0, 1'b0);
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_fill: valid %b in_ready %b expected 1 0",
                         bus.out_valid, bus.in_ready);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || observed() !== '0) begin
      errors++; $display("FAIL rst_async: valid %b in_ready %b out %h expected 0 1 0",
                         bus.out_valid, bus.in_ready, observed());
    end
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    drive_txn(W'(20), W'(22), 1'b0, 1'b0);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_first_accept: in_ready %b expected 1", bus.in_ready);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_stale: out_valid %b expected 0", bus.out_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.sum !== W'(42)) begin
      errors++; $display("FAIL rst_after: valid %b sum %h expected 1 %h",
                         bus.out_valid, bus.sum, W'(42));
    end
    repeat (3) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL rst_no_dup: out_valid %b expected 0", bus.out_valid);
      end
    end
  endtask

  task automatic test_random(input int n);
    int           sent;
    int           got;
    int           cycles;
    logic         hold_pend;
    logic [W+2:0] held;
    logic [W+2:0] exp;
    sent      = 0;
    got       = 0;
    cycles    = 0;
    hold_pend = 1'b0;
    held      = '0;
    exp_q.delete();
    while (got < n && cycles < n * 4 + 200) begin
      @(negedge clk);
      cycles++;
      bus.in_valid  = (sent < n) && ($urandom_range(0, 3) != 0);
      bus.a         = W'($urandom);
      bus.b         = W'($urandom);
      bus.cin       = 1'($urandom_range(0, 1));
      bus.sub       = 1'($urandom_range(0, 1));
      // Bias some operands to the extremes so carry chains run full length.
      if ($urandom_range(0, 7) == 0) bus.a = '1;
      if ($urandom_range(0, 7) == 0) bus.b = bus.sub ? bus.a : ~bus.a;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (hold_pend) begin
        checks++;
        if (bus.out_valid !== 1'b1 || observed() !== held) begin
          errors++; $display("FAIL rand_stall_hold: valid %b out %h expected 1 %h",
                             bus.out_valid, observed(), held);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_unexpected: got %h expected no output", observed());
        end else begin
          exp = exp_q.pop_front();
          if (observed() !== exp) begin
            errors++; $display("FAIL rand_result_%0d: got %h expected %h", got, observed(), exp);
          end
        end
        got++;
      end
      hold_pend = bus.out_valid && !bus.out_ready;
      held      = observed();
    end
    checks++;
    if (got != n) begin
      errors++; $display("FAIL rand_timeout: got %0d results expected %0d", got, n);
    end
    @(negedge clk);
    drive_idle();
    bus.out_ready = 1'b1;
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random(10000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_adder.md
# pipelined_cla_adder

Parametrised, two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshakes on input and output. It is the ALU's add/sub datapath. It generalises the two-bit lookahead cell to WIDTH bits organised as WIDTH/GROUP lookahead groups, and adds registered propagate/generate, a subtract mode, backpressure and status flags.

## Interface
- WIDTH, 32, operand and result width. Must be a multiple of GROUP and ≥ GROUP.
- GROUP, 4, bits per lookahead group. Legal values are 2, 4 or 8.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand transaction present.
- in_ready  output  1  block can accept a transaction this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry in; ignored when sub=1.
- sub  input  1  1 = compute a − b; 0 = compute a + b + cin.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB; for subtraction this is the no-borrow flag.
- overflow  output  1  signed overflow.
- zero  output  1  sum == 0.

## Operation
- Effective operands:
  - b' = sub ? ~b : b.
  - c0 = sub ? 1 : cin.
- Stage 1 (S1) registers, captured on accept:
  - p = a ^ b' and g = a & b', both WIDTH bits.
  - Per group k: P[k] = AND of p over the group. G[k] = the standard group generate (g[msb] | p[msb]&g[msb−1] | …).
  - c0.
- Stage 2 (S2) registers:
  - Group carries C[0] = c0, C[k+1] = G[k] | P[k]&C[k].
  - In-group bit carries are derived from C[k] and the registered p/g.
  - sum = p ^ carries.
  - cout = carry into bit WIDTH.
  - overflow = carry into bit WIDTH ^ carry into bit WIDTH−1.
  - zero = (sum == 0).
- The result must be bit-identical to (a + b' + c0) mod 2^WIDTH for every input.
- Handshake:
  - s2_adv = !s2_valid | out_ready.
  - in_ready = !s1_valid | s2_adv. This combinational out_ready→in_ready path is permitted.
  - An input is accepted when in_valid & in_ready. An output is consumed when out_valid & out_ready.
  - While out_valid=1 and out_ready=0, sum, cout, overflow and zero hold stable.
  - Transactions are never dropped, duplicated or reordered.
  - a, b, cin and sub are don't-care when in_valid=0.
- Simultaneous events: in the same cycle, S1 may accept a new input, S1 may move to S2, and S2 may be consumed. The result is full throughput of one transaction per cycle.

## Timing
- Latency: an input accepted at rising edge N gives out_valid=1 after edge N+1, i.e. in the following cycle. Total latency is 2 clock edges.
- Throughput: 1 transaction per cycle while out_ready=1.
- Capacity: 2 transactions in flight (S1 and S2). With out_ready=0 and both stages full, in_ready=0.
- Reset: asserting rst immediately clears s1_valid, s2_valid, sum, cout, overflow and zero to 0.
  - in_ready reads 1 during and after reset.
  - Reset mid-operation discards all in-flight transactions.
  - The first accept can occur at the first rising edge after rst deasserts.
- Idle: S1 and S2 contents are not updated when their stage does not advance.

## Configuration
- CLA_FLAGS_EN defined: the overflow and zero logic is built and registered in S2 as described above.
- CLA_FLAGS_EN undefined: overflow and zero are tied to constant 0 and the related flag logic is removed. sum, cout and the handshake are unchanged.

## Test plan
- WIDTH=32, GROUP=4, flags on: a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0, accepted at edge N → out_valid after edge N+1 with sum=0x00000000, cout=1, zero=1, overflow=0.
- a=0x7FFFFFFF, b=0x00000001, sub=0 → sum=0x80000000, cout=0, overflow=1, zero=0.
- a=5, b=7, sub=1, cin=0 (cin is ignored) → sum=0xFFFFFFFE, cout=0, overflow=0. Then a=7, b=5, sub=1 → sum=0x00000002, cout=1.
- Backpressure: issue 4 back-to-back inputs (1+1, 2+2, 3+3, 4+4) with out_ready=0 for 5 cycles.
  - in_ready must drop after 2 accepts.
  - sum must hold 0x2 stable.
  - After out_ready=1, results 2, 4, 6, 8 must appear in consecutive cycles.
- Reset mid-operation: assert rst with both stages valid → out_valid=0, sum=0 and in_ready=1 asynchronously. No stale result may appear after release.
- Random sweep of 10k transactions with random out_ready, run at WIDTH=8/GROUP=2 and WIDTH=64/GROUP=8, with and without CLA_FLAGS_EN → all results match the a + b' + c0 model in order. Without the macro, overflow and zero stay 0.
